// File: rtl/isp_common_pkg.sv
// Shared ISP types and helpers: per-axis lock state and a saturating increment.
// sat_inc works on values up to 32 bits; callers cast to and from their own width.
package isp_common_pkg;

    typedef enum logic [0:0] {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
        logic [31:0] result;
        if (value >= max_value) begin
            result = value;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/axis_lock_tracker.sv
// One measurement axis: length counter, compare, and lock FSM with hysteresis.
// Optional saturating error counter when FRAME_GEOM_ERRCNT_EN is defined. CNT_W up to 32.
module axis_lock_tracker
    import isp_common_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int LOCK_CNT = 15,
    parameter int LOSS_CNT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             evt,
    input  logic             cnt_en,
    input  logic [CNT_W-1:0] expected,
    output logic [CNT_W-1:0] meas_len,
    output logic             locked,
    output logic             mismatch
`ifdef FRAME_GEOM_ERRCNT_EN
    ,
    output logic [15:0]      err_cnt
`endif
);

    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W  = $clog2(LOSS_CNT + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [MATCH_W-1:0] LOCK_TGT = MATCH_W'(LOCK_CNT);
    localparam logic [MISS_W-1:0]  LOSS_TGT = MISS_W'(LOSS_CNT);

    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic               armed_r, armed_s;
    lock_state_e        state_r, state_s;
    logic [MATCH_W-1:0] match_cnt_r, match_cnt_s, match_inc_s;
    logic [MISS_W-1:0]  miss_cnt_r, miss_cnt_s, miss_inc_s;
    logic [CNT_W-1:0]   meas_len_r, meas_len_s;
    logic               mismatch_r, mismatch_s;
    logic               hit_s;

    // Next-state: counting, measurement on armed events, and lock hysteresis.
    always_comb begin
        cnt_s       = cnt_r;
        armed_s     = armed_r;
        state_s     = state_r;
        match_cnt_s = match_cnt_r;
        miss_cnt_s  = miss_cnt_r;
        meas_len_s  = meas_len_r;
        mismatch_s  = 1'b0;
        // A zero target or a saturated counter can never count as a match.
        hit_s       = (cnt_r == expected) && (expected != '0) && (cnt_r != CNT_MAX);
        match_inc_s = MATCH_W'(sat_inc(32'(match_cnt_r), 32'(LOCK_CNT)));
        miss_inc_s  = MISS_W'(sat_inc(32'(miss_cnt_r), 32'(LOSS_CNT)));
        if (evt) begin
            cnt_s   = CNT_ONE;
            armed_s = 1'b1;
            if (armed_r) begin
                meas_len_s = cnt_r;
                mismatch_s = ~hit_s;
                case (state_r)
                    UNLOCKED: begin
                        if (hit_s) begin
                            match_cnt_s = match_inc_s;
                            if (match_inc_s == LOCK_TGT) begin
                                state_s    = LOCKED;
                                miss_cnt_s = '0;
                            end else begin
                                state_s = UNLOCKED;
                            end
                        end else begin
                            match_cnt_s = '0;
                        end
                    end
                    LOCKED: begin
                        if (hit_s) begin
                            miss_cnt_s = '0;
                        end else begin
                            miss_cnt_s = miss_inc_s;
                            if (miss_inc_s == LOSS_TGT) begin
                                state_s     = UNLOCKED;
                                match_cnt_s = '0;
                            end else begin
                                state_s = LOCKED;
                            end
                        end
                    end
                    default: state_s = UNLOCKED;
                endcase
            end else begin
                meas_len_s = meas_len_r;
            end
        end else if (cnt_en) begin
            cnt_s = CNT_W'(sat_inc(32'(cnt_r), 32'(CNT_MAX)));
        end else begin
            cnt_s = cnt_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r       <= '0;
            armed_r     <= 1'b0;
            state_r     <= UNLOCKED;
            match_cnt_r <= '0;
            miss_cnt_r  <= '0;
            meas_len_r  <= '0;
            mismatch_r  <= 1'b0;
        end else begin
            cnt_r       <= cnt_s;
            armed_r     <= armed_s;
            state_r     <= state_s;
            match_cnt_r <= match_cnt_s;
            miss_cnt_r  <= miss_cnt_s;
            meas_len_r  <= meas_len_s;
            mismatch_r  <= mismatch_s;
        end
    end

    assign meas_len = meas_len_r;
    assign locked   = (state_r == LOCKED);
    assign mismatch = mismatch_r;

`ifdef FRAME_GEOM_ERRCNT_EN
    logic [15:0] err_cnt_r;

    // Error counter steps together with the mismatch pulse; cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_r <= 16'h0000;
        end else if (mismatch_s) begin
            err_cnt_r <= 16'(sat_inc(32'(err_cnt_r), 32'h0000_FFFF));
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign err_cnt = err_cnt_r;
`endif

endmodule

// File: rtl/frame_geometry_monitor.sv
// Passive line-length / frame-height monitor with per-axis lock tracking.
// Define FRAME_GEOM_ERRCNT_EN to add the h_err_cnt / v_err_cnt ports.
module frame_geometry_monitor
    import isp_common_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int LOCK_CNT = 15,
    parameter int LOSS_CNT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             hstart,
    input  logic             fstart,
    input  logic [CNT_W-1:0] h_pixel,
    input  logic [CNT_W-1:0] v_pixel,
    output logic [CNT_W-1:0] h_len,
    output logic [CNT_W-1:0] v_len,
    output logic             h_locked,
    output logic             v_locked,
    output logic             locked,
    output logic             h_mismatch,
    output logic             v_mismatch
`ifdef FRAME_GEOM_ERRCNT_EN
    ,
    output logic [15:0]      h_err_cnt,
    output logic [15:0]      v_err_cnt
`endif
);

    logic h_evt_s, h_inc_s, v_evt_s, v_inc_s;

    // fstart also opens a line, so it is a vertical event rather than a line increment.
    assign h_evt_s = in_valid & hstart;
    assign h_inc_s = in_valid;
    assign v_evt_s = in_valid & fstart;
    assign v_inc_s = in_valid & hstart & ~fstart;

    axis_lock_tracker #(.CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)) u_h_axis (
        .clk      (clk),
        .reset    (reset),
        .evt      (h_evt_s),
        .cnt_en   (h_inc_s),
        .expected (h_pixel),
        .meas_len (h_len),
        .locked   (h_locked),
        .mismatch (h_mismatch)
`ifdef FRAME_GEOM_ERRCNT_EN
        ,
        .err_cnt  (h_err_cnt)
`endif
    );

    axis_lock_tracker #(.CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)) u_v_axis (
        .clk      (clk),
        .reset    (reset),
        .evt      (v_evt_s),
        .cnt_en   (v_inc_s),
        .expected (v_pixel),
        .meas_len (v_len),
        .locked   (v_locked),
        .mismatch (v_mismatch)
`ifdef FRAME_GEOM_ERRCNT_EN
        ,
        .err_cnt  (v_err_cnt)
`endif
    );

    assign locked = h_locked & v_locked;

endmodule

// File: tb/tb_frame_geometry_monitor.sv
// Self-checking bench for frame_geometry_monitor: per-beat scoreboard plus segment table
// and hand-written hysteresis / reset / saturation sequences.
module tb_frame_geometry_monitor;

    localparam int LOCK_CNT = 15;
    localparam int LOSS_CNT = 2;
    localparam int CMAX     = 65535;

    logic        clk = 1'b0;
    logic        reset, in_valid, hstart, fstart;
    logic [15:0] h_pixel, v_pixel, h_len, v_len;
    logic        h_locked, v_locked, locked, h_mismatch, v_mismatch;
    logic [3:0]  h_pixel4, v_pixel4, h_len4, v_len4;
    logic        h_locked4, v_locked4, locked4, h_mismatch4, v_mismatch4;
`ifdef FRAME_GEOM_ERRCNT_EN
    logic [15:0] h_err_cnt, v_err_cnt, h_err_cnt4, v_err_cnt4;
`endif

    always #5 clk = ~clk;

    frame_geometry_monitor #(.CNT_W(16), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .hstart(hstart), .fstart(fstart),
        .h_pixel(h_pixel), .v_pixel(v_pixel), .h_len(h_len), .v_len(v_len),
        .h_locked(h_locked), .v_locked(v_locked), .locked(locked),
        .h_mismatch(h_mismatch), .v_mismatch(v_mismatch)
`ifdef FRAME_GEOM_ERRCNT_EN
        , .h_err_cnt(h_err_cnt), .v_err_cnt(v_err_cnt)
`endif
    );

    frame_geometry_monitor #(.CNT_W(4), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .hstart(hstart), .fstart(fstart),
        .h_pixel(h_pixel4), .v_pixel(v_pixel4), .h_len(h_len4), .v_len(v_len4),
        .h_locked(h_locked4), .v_locked(v_locked4), .locked(locked4),
        .h_mismatch(h_mismatch4), .v_mismatch(v_mismatch4)
`ifdef FRAME_GEOM_ERRCNT_EN
        , .h_err_cnt(h_err_cnt4), .v_err_cnt(v_err_cnt4)
`endif
    );

    typedef struct packed {
        logic [15:0] h_len;
        logic [15:0] v_len;
        logic        hl;
        logic        vl;
        logic        l;
        logic        hm;
        logic        vm;
`ifdef FRAME_GEOM_ERRCNT_EN
        logic [15:0] he;
        logic [15:0] ve;
`endif
    } obs_t;

    typedef struct {
        int hp; int vp; int frames; int lines; int pix; bit gap;
        int exp_h_len; int exp_v_len; bit exp_hl; bit exp_vl;
    } seg_t;

    int   total = 0;
    int   bad   = 0;
    int   hs_events = 0;
    int   fs_events = 0;
    bit   hl_seen = 0;
    bit   l_seen  = 0;
    obs_t exp_q[$];
    seg_t segs[3];

    int m_cnt[2], m_armed[2], m_match[2], m_miss[2], m_locked[2], m_len[2], m_mism[2], m_err[2];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int a = 0; a < 2; a++) begin
            m_cnt[a] = 0; m_armed[a] = 0; m_match[a] = 0; m_miss[a] = 0;
            m_locked[a] = 0; m_len[a] = 0; m_mism[a] = 0; m_err[a] = 0;
        end
    endtask

    task automatic model_axis(input int a, input bit evt, input bit inc, input int expv);
        bit ok;
        m_mism[a] = 0;
        if (evt) begin
            if (m_armed[a] != 0) begin
                ok = (expv != 0) && (m_cnt[a] == expv) && (m_cnt[a] != CMAX);
                m_len[a]  = m_cnt[a];
                m_mism[a] = ok ? 0 : 1;
                if (!ok && m_err[a] < 65535) m_err[a]++;
                if (m_locked[a] != 0) begin
                    if (ok) m_miss[a] = 0;
                    else begin
                        m_miss[a]++;
                        if (m_miss[a] >= LOSS_CNT) begin m_locked[a] = 0; m_match[a] = 0; end
                    end
                end else if (ok) begin
                    if (m_match[a] < LOCK_CNT) m_match[a]++;
                    if (m_match[a] >= LOCK_CNT) begin m_locked[a] = 1; m_miss[a] = 0; end
                end else begin
                    m_match[a] = 0;
                end
            end
            m_armed[a] = 1;
            m_cnt[a]   = 1;
        end else if (inc && m_cnt[a] < CMAX) begin
            m_cnt[a]++;
        end
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.h_len = 16'(m_len[0]);
        o.v_len = 16'(m_len[1]);
        o.hl = (m_locked[0] != 0);
        o.vl = (m_locked[1] != 0);
        o.l  = (m_locked[0] != 0) && (m_locked[1] != 0);
        o.hm = (m_mism[0] != 0);
        o.vm = (m_mism[1] != 0);
`ifdef FRAME_GEOM_ERRCNT_EN
        o.he = 16'(m_err[0]);
        o.ve = 16'(m_err[1]);
`endif
        return o;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.h_len = h_len; o.v_len = v_len;
        o.hl = h_locked; o.vl = v_locked; o.l = locked;
        o.hm = h_mismatch; o.vm = v_mismatch;
`ifdef FRAME_GEOM_ERRCNT_EN
        o.he = h_err_cnt; o.ve = v_err_cnt;
`endif
        return o;
    endfunction

    // Drive one cycle, push the model's expectation, and compare after the edge.
    task automatic beat(input bit rst, input bit v, input bit hs, input bit fs);
        obs_t e, a;
        @(negedge clk);
        reset = rst; in_valid = v; hstart = hs; fstart = fs;
        if (rst) model_reset();
        else begin
            model_axis(0, v && hs, v, int'(h_pixel));
            model_axis(1, v && fs, v && hs && !fs, int'(v_pixel));
            if (v && hs) hs_events++;
            if (v && fs) fs_events++;
        end
        exp_q.push_back(model_obs());
        @(posedge clk);
        #1;
        a = dut_obs();
        e = exp_q.pop_front();
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL beat t=%0t act=%h exp=%h", $time, a, e);
        end
        if (!hl_seen && h_locked) begin
            hl_seen = 1;
            check("h_lock_rise_hstarts", hs_events, 16);
        end
        if (!l_seen && locked) begin
            l_seen = 1;
            check("lock_rise_fstarts", fs_events, 16);
        end
    endtask

    task automatic pixels(input int n);
        for (int i = 0; i < n; i++) beat(0, 1, 0, 0);
    endtask

    task automatic close_line(input string name, input int exp_len, input bit exp_m, input bit exp_l);
        beat(0, 1, 1, 0);
        check({name, "_h_len"}, int'(h_len), exp_len);
        check({name, "_h_mismatch"}, int'(h_mismatch), int'(exp_m));
        check({name, "_h_locked"}, int'(h_locked), int'(exp_l));
    endtask

    task automatic run_seg(input int s);
        h_pixel = 16'(segs[s].hp);
        v_pixel = 16'(segs[s].vp);
        for (int f = 0; f < segs[s].frames; f++)
            for (int l = 0; l < segs[s].lines; l++)
                for (int p = 0; p < segs[s].pix; p++) begin
                    if (segs[s].gap && (p % 2 == 1)) beat(0, 0, 1, 1);
                    beat(0, 1, p == 0, (p == 0) && (l == 0));
                end
        check($sformatf("seg%0d_h_len", s), int'(h_len), segs[s].exp_h_len);
        check($sformatf("seg%0d_v_len", s), int'(v_len), segs[s].exp_v_len);
        check($sformatf("seg%0d_h_locked", s), int'(h_locked), int'(segs[s].exp_hl));
        check($sformatf("seg%0d_v_locked", s), int'(v_locked), int'(segs[s].exp_vl));
    endtask

    initial begin
        segs[0] = '{hp: 8, vp: 4, frames: 17, lines: 4, pix: 8, gap: 0,
                    exp_h_len: 8, exp_v_len: 4, exp_hl: 1, exp_vl: 1};
        segs[1] = '{hp: 8, vp: 4, frames: 2, lines: 4, pix: 8, gap: 1,
                    exp_h_len: 8, exp_v_len: 4, exp_hl: 0, exp_vl: 1};
        segs[2] = '{hp: 0, vp: 4, frames: 1, lines: 4, pix: 8, gap: 0,
                    exp_h_len: 8, exp_v_len: 4, exp_hl: 0, exp_vl: 1};

        reset = 1'b1; in_valid = 1'b0; hstart = 1'b0; fstart = 1'b0;
        h_pixel = 16'd8; v_pixel = 16'd4; h_pixel4 = 4'd15; v_pixel4 = 4'd4;
        model_reset();
        beat(1, 0, 0, 0);
        beat(1, 1, 1, 1);
        check("reset_h_len", int'(h_len), 0);
        check("reset_locked", int'(locked), 0);

        // Nominal lock.
        run_seg(0);

        // Hysteresis: isolated short line keeps lock, two in a row drop it.
        close_line("hyst_ok", 8, 0, 1);   pixels(6);
        close_line("hyst_one", 7, 1, 1);  pixels(7);
        close_line("hyst_back", 8, 0, 1); pixels(6);
        close_line("hyst_a", 7, 1, 1);    pixels(6);
        close_line("hyst_b", 7, 1, 0);    pixels(7);

        // Gapped valid, then zero target.
        run_seg(1);
        run_seg(2);

        // Reset mid-line, then re-arm on a fresh hstart.
        h_pixel = 16'd8;
        beat(0, 1, 0, 0);
        beat(1, 1, 0, 0);
        check("rst_mid_h_len", int'(h_len), 0);
        check("rst_mid_h_locked", int'(h_locked), 0);
        close_line("arm_first", 0, 0, 0); pixels(7);
        close_line("arm_second", 8, 0, 0);
        check("arm_v_len", int'(v_len), 0);

        // Saturation: 20-beat line on the 4-bit instance.
        pixels(19);
        close_line("sat_main", 20, 1, 0);
        check("sat4_h_len", int'(h_len4), 15);
        check("sat4_h_mismatch", int'(h_mismatch4), 1);

`ifdef FRAME_GEOM_ERRCNT_EN
        beat(1, 0, 0, 0);
        v_pixel = 16'd5;
        for (int f = 0; f < 4; f++)
            for (int l = 0; l < 4; l++)
                for (int p = 0; p < 8; p++) beat(0, 1, p == 0, (p == 0) && (l == 0));
        check("err_v_cnt", int'(v_err_cnt), 3);
        beat(1, 0, 0, 0);
        check("err_v_cnt_reset", int'(v_err_cnt), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
